// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and writeback source encoding for the integer register file control path.
package regfile_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer advances whenever a grant is issued.
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e last_grant_reg;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant_reg == WB_MEM) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= WB_MEM;
        end else if (|gnt) begin
            last_grant_reg <= gnt[1] ? WB_MEM : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load writeback and keeps
// a busy scoreboard of pending destinations so issue can stall on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            claim_valid,
    input  logic [AW-1:0]   claim_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rf_wr_en,
    output logic [AW-1:0]   rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data
);

    logic [1:0]      gnt;
    logic [NREG-1:0] busy_reg;
    logic            accept;
    logic            wr_take;
    logic            claim_take;
    logic [AW-1:0]   acc_rd;
    logic [XLEN-1:0] acc_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({mem_valid, alu_valid}),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[WB_ALU];
    assign mem_ready = gnt[WB_MEM];
    assign accept    = |gnt;
    assign acc_rd    = gnt[WB_MEM] ? mem_rd   : alu_rd;
    assign acc_data  = gnt[WB_MEM] ? mem_data : alu_data;

    // A request is still accepted during flush, but its result is dropped.
    assign wr_take = accept && !flush && (acc_rd != '0);

    assign stall      = claim_valid && (busy_reg[rs1] || busy_reg[rs2] || busy_reg[claim_rd]);
    assign claim_take = claim_valid && !stall && !flush && (claim_rd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en <= wr_take;
            if (wr_take) begin
                rf_wr_addr <= acc_rd;
                rf_wr_data <= acc_data;
            end
        end
    end

    // x0 never becomes busy; elsewhere a new claim overrides a retiring write.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_reg[gi] = 1'b0;
            end else begin : g_bit
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        busy_reg[gi] <= 1'b0;
                    end else if (flush) begin
                        busy_reg[gi] <= 1'b0;
                    end else if (claim_take && (claim_rd == AW'(gi))) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (rf_wr_en && (rf_wr_addr == AW'(gi))) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and scoreboard for the 64-bit integer register file. It shares the file's single write port between two writeback requesters, the ALU and load paths, using round-robin arbitration with valid/ready handshakes. It also tracks destination registers with pending writes so the issue stage can stall on RAW/WAW hazards. It sits between execute/memory writeback and the register file write inputs (RD, WriteData, RegWrite).

## Interface
- XLEN, 64, data width
- NREG, 32, architectural registers; AW = clog2(NREG) = 5

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- claim_valid  in  1  issue stage reserves claim_rd
- claim_rd  in  AW  destination being issued
- rs1, rs2  in  AW  source registers of the instruction in issue
- stall  out  1  issue must hold; claim not taken
- alu_valid, alu_rd, alu_data  in  1/AW/XLEN  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid, mem_rd, mem_data  in  1/AW/XLEN  load writeback request
- mem_ready  out  1  load request accepted this cycle
- rf_wr_en, rf_wr_addr, rf_wr_data  out  1/AW/XLEN  to register file RegWrite/RD/WriteData, registered

## Operation
- State: busy[NREG-1:0] scoreboard; last_grant (0=ALU, 1=MEM); output register (rf_wr_en/addr/data).
- Arbitration, combinational: one valid requester is granted. With both valid, the requester not in last_grant is granted. last_grant updates only on acceptance. ready = grant; accept = valid & ready.
- Accepted request loads the output register: rf_wr_en=1 only if rd≠0. Otherwise rf_wr_en=0 and rf_wr_addr/rf_wr_data are left unchanged.
- No acceptance: rf_wr_en=0 the next cycle.
- Requesters hold valid/rd/data stable until ready. A request must not drop valid before it is accepted.
- Hazard: stall = claim_valid & (busy[rs1] | busy[rs2] | busy[claim_rd]). Reads of index 0 are always 0.
- Claim: when claim_valid & ~stall & claim_rd≠0, set busy[claim_rd].
- Clear: when rf_wr_en=1, clear busy[rf_wr_addr] at the end of that cycle.
- Simultaneous set and clear of the same index: set wins.
- busy[0] is hard-wired 0.
- flush: clears all busy bits and forces rf_wr_en=0 next cycle. A pending output write is dropped. ready is still generated and an accepted request is discarded. flush has priority over claim and accept.

## Timing
- Reset (async assert, sync-safe deassert): busy=0, last_grant=1 (ALU wins first tie), rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0. stall/ready then follow inputs combinationally.
- Accept at edge N: rf_wr_en high during cycle N..N+1, one cycle. Busy bit clears at edge N+1. A dependent instruction can issue in cycle N+1..N+2.
- Throughput: one write per cycle, sustained. Under continuous contention the requesters strictly alternate.
- Claim to busy visible: next cycle. Claim and its own writeback can be accepted in the same cycle only if the claim edge precedes acceptance; otherwise set-wins applies.
- stall, alu_ready, mem_ready: purely combinational, zero latency. There are no paths from rf_* back to inputs.

## Structure
- Package regfile_ctrl_pkg holds XLEN, NREG, AW, and an enum wb_src_e {WB_ALU, WB_MEM}.
- Sub-module rr_arbiter2 (2-way round-robin: req[1:0] → gnt[1:0], pointer update on accept). It is reused later for memory-port sharing.
- Top contains the scoreboard, output register, and flush/hazard logic.

## Test plan
- Reset mid-write: rf_wr_en=1 at reset assertion → all outputs 0 immediately, busy=0, stall=0.
- Both requesters valid for 4 cycles (alu_rd=5, mem_rd=6) → grants ALU, MEM, ALU, MEM. rf_wr_addr=5,6,5,6, one cycle after each accept.
- claim_rd=7 → next cycle rs1=7 gives stall=1. mem writes rd=7 data 0xDEAD → rf_wr_en with addr 7, data 0xDEAD, then stall=0 the following cycle.
- Writeback to rd=0 with data 0xFFFF → ready=1, rf_wr_en stays 0. Claim of rd=0 never sets busy and never stalls.
- Claim rd=9 in the same cycle busy[9] clears → busy[9]=1 afterwards (set wins). Claim rd=9 while busy → stall=1, no change.
- flush with busy={3,4} and a pending write → busy=0, rf_wr_en=0 next cycle, stall=0.
